// File: rtl/dr_reorder_pkg.sv
// Shared constants and sample layout for the digit-reverse reorder buffer.
package dr_reorder_pkg;

  localparam int unsigned W    = 32;
  localparam int unsigned NDIG = 4;
  localparam int unsigned N    = 3 ** NDIG;
  localparam int unsigned AW   = $clog2(N);

  // Complex sample: real half in the upper bits, imaginary half in the lower bits.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t;

endpackage

// File: rtl/dr_reorder_if.sv
// Streaming bus of the reorder buffer: FFT-side input, consumer-side output, drop flag.
interface dr_reorder_if;
  import dr_reorder_pkg::*;

  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           overflow;

  // Environment side: feeds FFT samples and consumes natural-order samples.
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, overflow
  );

  // Reorder buffer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, overflow
  );

endinterface

// File: rtl/dr_reorder_digrev3.sv
// Combinational base-3 digit reversal of a write index into a bank address.
module digrev3 #(
  parameter  int unsigned NDIG = dr_reorder_pkg::NDIG,
  localparam int unsigned N    = 3 ** NDIG,
  localparam int unsigned AW   = $clog2(N)
) (
  input  logic [AW-1:0] idx_i,
  output logic [AW-1:0] addr_o
);

  int unsigned rem_c;
  int unsigned rev_c;

  // Peel digits off the low end of the index and push them onto the high end of the address.
  always_comb begin
    rem_c = 32'(idx_i);
    rev_c = 0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      rev_c = (rev_c * 3) + (rem_c % 3);
      rem_c = rem_c / 3;
    end
    addr_o = AW'(rev_c);
  end

endmodule

// File: rtl/dr_reorder.sv
// Ping-pong reorder buffer: writes FFT output at digit-reversed addresses,
// reads each full bank back out in natural order.
module dr_reorder #(
  parameter int unsigned W    = dr_reorder_pkg::W,
  parameter int unsigned NDIG = dr_reorder_pkg::NDIG
) (
  input  logic         clk,
  input  logic         rst_n,
  dr_reorder_if.slave  bus
);

  localparam int unsigned N    = 3 ** NDIG;
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned LAST = N - 1;

  logic [W-1:0]  mem_q [2][N];

  logic          wb_q,   wb_d;
  logic          rb_q,   rb_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    full_q, full_d;
  logic          ovf_q,  ovf_d;

  logic [AW-1:0] wr_addr_c;
  logic          wr_en_c;
  logic          rd_xfer_c;
  logic          wr_last_c;
  logic          rd_last_c;

  digrev3 #(.NDIG(NDIG)) u_digrev (
    .idx_i  (wcnt_q),
    .addr_o (wr_addr_c)
  );

  // Next-state for both pointers, counters, full flags and the drop flag.
  always_comb begin
    wb_d   = wb_q;
    rb_d   = rb_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    full_d = full_q;
    ovf_d  = 1'b0;

    // Full flags are sampled before update, so a bank freed this cycle still rejects a write.
    wr_en_c   = bus.in_valid & ~full_q[wb_q];
    rd_xfer_c = full_q[rb_q] & bus.out_ready;
    wr_last_c = (wcnt_q == AW'(LAST));
    rd_last_c = (rcnt_q == AW'(LAST));

    if (wr_en_c) begin
      if (wr_last_c) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wcnt_d       = '0;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end

    // A transfer only happens on a full bank and a write only on an empty one,
    // so the set and clear below never target the same flag.
    if (rd_xfer_c) begin
      if (rd_last_c) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rcnt_d       = '0;
      end else begin
        rcnt_d = rcnt_q + AW'(1);
      end
    end

    ovf_d = bus.in_valid & full_q[wb_q];
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      full_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  // Sample storage; contents survive reset and are simply overwritten by the next frame.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wb_q][wr_addr_c] <= bus.in_data;
    end
  end

  assign bus.out_valid = full_q[rb_q];
  assign bus.out_data  = mem_q[rb_q][rcnt_q];
  assign bus.out_last  = full_q[rb_q] & rd_last_c;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_dr_reorder.sv
// Scoreboard bench for the digit-reverse reorder buffer.
module tb_dr_reorder;
  import dr_reorder_pkg::*;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dr_reorder_if bus_if ();

  dr_reorder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [AW-1:0] chk_idx;
  logic [AW-1:0] chk_addr;

  digrev3 #(.NDIG(NDIG)) u_chk (
    .idx_i  (chk_idx),
    .addr_o (chk_addr)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovf_cnt = 0;
  int   xfer_cnt = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic [3:0] pat = 4'b1001;

  // Reference digit reversal written out digit by digit for the 4-digit frame.
  function automatic int unsigned tb_digrev(int unsigned k);
    int unsigned d0, d1, d2, d3;
    d0 = k % 3;
    d1 = (k / 3) % 3;
    d2 = (k / 9) % 3;
    d3 = k / 27;
    return d0 * 27 + d1 * 9 + d2 * 3 + d3;
  endfunction

  // Sample tagged with frame id in the real half and natural index in the imaginary half.
  function automatic logic [W-1:0] mk(int unsigned f, int unsigned j);
    sample_t s;
    s.re = 16'(f);
    s.im = 16'(j);
    return W'(s);
  endfunction

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input int unsigned f);
    exp_t e;
    for (int unsigned j = 0; j < N; j++) begin
      e.data = mk(f, j);
      e.last = (j == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    bus_if.in_valid  = v;
    bus_if.in_data   = d;
    bus_if.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input int unsigned f, input logic r);
    for (int unsigned k = 0; k < N; k++) begin
      drive(1'b1, mk(f, tb_digrev(k)), r);
    end
    bus_if.in_valid = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready cycles 1,0,0,1.
  task automatic drain(input int mode, input int budget);
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      drive(1'b0, '0, (mode == 0) ? 1'b1 : pat[i % 4]);
    end
    check_int("drain_remaining", exp_q.size(), 0);
    bus_if.out_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every transfer, checks stall stability, counts drops.
  initial begin
    logic       prev_stall;
    logic [W-1:0] prev_data;
    exp_t       e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_if.overflow === 1'b1) ovf_cnt++;
      if (prev_stall && bus_if.out_valid === 1'b1)
        check_word("hold_data", bus_if.out_data, prev_data);
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h want none at %0t", bus_if.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check_word("out_data", bus_if.out_data, e.data);
          check_bit("out_last", bus_if.out_last, e.last);
        end
        xfer_cnt++;
        last_cyc = cyc;
      end
      prev_stall = (bus_if.out_valid === 1'b1) && (bus_if.out_ready === 1'b0);
      prev_data  = bus_if.out_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int ovf0;
    int c_first;

    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    chk_idx          = '0;

    // Address mapping of the digit-reverse unit.
    chk_idx = AW'(1);  #1; check_int("digrev_1",  int'(chk_addr), 27);
    chk_idx = AW'(5);  #1; check_int("digrev_5",  int'(chk_addr), 63);
    chk_idx = AW'(80); #1; check_int("digrev_80", int'(chk_addr), 80);
    chk_idx = AW'(2);  #1; check_int("digrev_2",  int'(chk_addr), 54);

    // Reset state.
    #20;
    check_bit("rst_out_valid", bus_if.out_valid, 1'b0);
    check_bit("rst_out_last",  bus_if.out_last,  1'b0);
    check_bit("rst_overflow",  bus_if.overflow,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1);

    // Ramp frame and one-cycle latency.
    push_frame(1);
    for (int unsigned k = 0; k < N; k++) begin
      if (k == N - 1) check_bit("pre_latency_valid", bus_if.out_valid, 1'b0);
      drive(1'b1, mk(1, tb_digrev(k)), 1'b1);
    end
    bus_if.in_valid = 1'b0;
    check_bit("latency_valid", bus_if.out_valid, 1'b1);
    drain(0, 200);
    check_int("ramp_overflow", ovf_cnt, 0);

    // Three frames back to back, continuous output.
    base = xfer_cnt;
    ovf0 = ovf_cnt;
    push_frame(2);
    push_frame(3);
    push_frame(4);
    write_frame(2, 1'b1);
    c_first = cyc + 1;
    write_frame(3, 1'b1);
    write_frame(4, 1'b1);
    drain(0, 300);
    check_int("b2b_count", xfer_cnt - base, 3 * N);
    check_int("b2b_span", last_cyc - c_first, 3 * N - 1);
    check_int("b2b_overflow", ovf_cnt - ovf0, 0);

    // Full backpressure: third frame is dropped sample by sample.
    ovf0 = ovf_cnt;
    push_frame(5);
    push_frame(6);
    write_frame(5, 1'b0);
    write_frame(6, 1'b0);
    write_frame(7, 1'b0);
    drive(1'b0, '0, 1'b0);
    check_int("bp_overflow", ovf_cnt - ovf0, N);
    check_bit("bp_valid", bus_if.out_valid, 1'b1);
    check_word("bp_head", bus_if.out_data, mk(5, 0));
    check_bit("bp_last", bus_if.out_last, 1'b0);
    drain(0, 400);
    check_int("bp_overflow_after", ovf_cnt - ovf0, N);

    // Stall pattern on the read side.
    base = xfer_cnt;
    push_frame(8);
    write_frame(8, 1'b0);
    drain(1, 400);
    check_int("stall_count", xfer_cnt - base, N);

    // Reset with a partial write frame and a partially read frame.
    push_frame(9);
    write_frame(9, 1'b0);
    base = xfer_cnt;
    for (int unsigned i = 0; i < 40; i++) begin
      drive(1'b1, mk(10, tb_digrev(i)), (i >= 20));
    end
    check_int("pre_reset_reads", xfer_cnt - base, 20);
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    #1;
    check_bit("mid_rst_valid",    bus_if.out_valid, 1'b0);
    check_bit("mid_rst_last",     bus_if.out_last,  1'b0);
    check_bit("mid_rst_overflow", bus_if.overflow,  1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1);
    check_bit("post_rst_valid", bus_if.out_valid, 1'b0);
    push_frame(11);
    write_frame(11, 1'b1);
    drain(0, 200);
    check_int("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dr_reorder.md
DR_REORDER -- requirements
Module: dr_reorder

Interface
REQ-001 Parameter: W, 32, sample width; [31:16] real, [15:0] imaginary, two's complement; passed through unmodified.
REQ-002 Parameter: NDIG, 4, number of radix-3 digits; frame length N = 3^NDIG = 81.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  in_data carries a digit-reversed-order FFT output sample this cycle.
REQ-006 Port: in_data  input  W  sample from the FFT pipeline.
REQ-007 Port: out_valid  output  1  out_data holds a natural-order sample.
REQ-008 Port: out_ready  input  1  consumer accepts the sample this cycle.
REQ-009 Port: out_data  output  W  natural-order sample.
REQ-010 Port: out_last  output  1  high with out_valid on the final sample (index N-1) of a frame.
REQ-011 Port: overflow  output  1  one-cycle pulse; an input sample was dropped.

Function
REQ-012 Storage SHALL be two banks (ping-pong) of N x W registers, each with a full flag.
REQ-013 Write side SHALL hold a write bank pointer wb and a write counter wcnt (0..N-1).
REQ-014 On in_valid with full[wb]=0, in_data SHALL be stored at bank wb, address digrev(wcnt), and wcnt SHALL advance.
REQ-015 digrev SHALL reverse base-3 digits: for wcnt = d3*27+d2*9+d1*3+d0, address = d0*27+d1*9+d2*3+d3.
REQ-016 On an accepted write with wcnt=N-1, the block SHALL set full[wb], toggle wb, and wrap wcnt to 0.
REQ-017 On in_valid with full[wb]=1 (registered value), the sample SHALL be dropped, wcnt SHALL hold, and overflow SHALL pulse in the next cycle.
REQ-018 Read side SHALL hold a read bank pointer rb and a read counter rcnt (0..N-1).
REQ-019 out_valid SHALL equal full[rb].
REQ-020 out_data SHALL equal bank rb at address rcnt, and out_last SHALL equal out_valid AND (rcnt=N-1).
REQ-021 A transfer SHALL occur when out_valid AND out_ready; rcnt SHALL then advance.
REQ-022 A transfer at rcnt=N-1 SHALL clear full[rb], toggle rb, and wrap rcnt to 0.
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Same-cycle set of full[wb] and clear of full[rb] on different banks SHALL both take effect.
REQ-025 A write arriving in the same cycle that the reader frees the target bank SHALL be dropped per REQ-017, because full is sampled before update.
REQ-026 Latency from the final write of a frame to out_valid=1 SHALL be 1 cycle when the other bank is idle.
REQ-027 Sustained throughput SHALL be 1 sample/cycle with out_ready held high.

Reset
REQ-028 On rst_n=0, the block SHALL asynchronously clear wb, rb, wcnt, rcnt, both full flags, and the overflow register to 0.
REQ-029 Under reset, out_valid, out_last, and overflow SHALL read 0.
REQ-030 Bank contents SHALL NOT be reset.
REQ-031 Reset mid-frame SHALL discard any partial or unread frame.

Structure
REQ-032 The shared package SHALL hold W, NDIG, N, and the sample typedef (re/im halves).
REQ-033 The digit-reverse address function SHALL be the single combinational sub-module digrev3, parameterised by NDIG.

Verification
REQ-034 Ramp test: write 81 samples with value = digrev(k) at step k, out_ready=1 -> outputs 0,1,...,80 in order; out_last at 80; first out_valid 1 cycle after the last write.
REQ-035 Address check: wcnt=1 -> address 27; wcnt=5 -> address 63; wcnt=80 -> address 80.
REQ-036 Back-to-back: 3 frames continuous with out_ready=1 -> 243 outputs, no overflow, no gap after the first frame.
REQ-037 Backpressure: out_ready=0 throughout while writing 3 frames -> frames 1-2 fill both banks; all 81 frame-3 samples dropped with 81 overflow pulses; out_data stable at sample 0.
REQ-038 Stall/hold: toggle out_ready 1,0,0,1 -> out_data unchanged during the stalled cycles; no sample lost or duplicated.
REQ-039 Reset mid-operation: assert rst_n=0 at write 40 and read 20 -> out_valid=0 immediately; after release, a fresh frame is reordered correctly from index 0.
